// File: rtl/ctu_cluster_rst_seq_pkg.sv
// Shared types and helpers for the cluster clock/reset sequencer.
package ctu_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_RAMP,
        ST_SETTLE,
        ST_RUN,
        ST_WRST,
        ST_DBG
    } seq_state_e;

    // Width of the shared down-counter: enough bits to hold the longest interval.
    function automatic int unsigned seq_cnt_w(input int unsigned rst_hold,
                                              input int unsigned stagger,
                                              input int unsigned sync_lat,
                                              input int unsigned dbg_width);
        int unsigned m;
        m = rst_hold;
        if (stagger > m)   m = stagger;
        if (sync_lat > m)  m = sync_lat;
        if (dbg_width > m) m = dbg_width;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ctu_cluster_rst_seq_if.sv
// Request/response bundle between the sequencer and its software/header side.
interface ctu_cluster_rst_seq_if #(
    parameter int unsigned NCLUST = 8
);
    logic [NCLUST-1:0] cken_req;
    logic              wrst_req;
    logic              dbg_req;
    logic [NCLUST-1:0] cluster_cken;
    logic              grst_l;
    logic              gdbginit_l;
    logic              seq_busy;
    logic              seq_done;

    modport master (
        output cken_req, wrst_req, dbg_req,
        input  cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done
    );

    modport slave (
        input  cken_req, wrst_req, dbg_req,
        output cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done
    );
endinterface

// File: rtl/ctu_cluster_rst_seq_cnt.sv
// Loadable saturating down-counter used to time every sequencer phase.
module ctu_seq_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;

    // Load has priority; otherwise count down and stick at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/ctu_cluster_rst_seq.sv
// Central clock/reset sequencer: power-on ramp, warm reset and debug init.
module ctu_cluster_rst_seq
    import ctu_rst_seq_pkg::*;
#(
    parameter int unsigned NCLUST    = 8,
    parameter int unsigned RST_HOLD  = 16,
    parameter int unsigned STAGGER   = 4,
    parameter int unsigned SYNC_LAT  = 8,
    parameter int unsigned DBG_WIDTH = 8
) (
    input  logic                  gclk,
    input  logic                  arst_l,
    ctu_cluster_rst_seq_if.slave  bus
);
    localparam int unsigned CNT_W = seq_cnt_w(RST_HOLD, STAGGER, SYNC_LAT, DBG_WIDTH);
    localparam int unsigned IDX_W = (NCLUST > 1) ? $clog2(NCLUST) : 1;

    seq_state_e        state, nxt_state;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              hold_armed, armed_nxt;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_zero;

    logic [NCLUST-1:0] cken_q, cken_nxt;
    logic              grst_q, grst_nxt;
    logic              gdb_q, gdb_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;

    ctu_seq_cnt #(.W(CNT_W)) u_cnt (
        .clk      (gclk),
        .rst_n    (arst_l),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // State, ramp index and power-on hold arming.
    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            state      <= ST_ASSERT;
            idx        <= '0;
            hold_armed <= 1'b0;
        end else begin
            state      <= nxt_state;
            idx        <= idx_nxt;
            hold_armed <= armed_nxt;
        end
    end

    // Next state and counter reloads; loads use N-1 so each phase lasts N edges.
    // The counter leaves reset at 0, so the first ASSERT cycle arms the hold.
    always_comb begin
        nxt_state = state;
        idx_nxt   = idx;
        armed_nxt = hold_armed;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        unique case (state)
            ST_ASSERT: begin
                if (!hold_armed) begin
                    armed_nxt = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_val   = CNT_W'(RST_HOLD - 1);
                end else if (cnt_zero) begin
                    idx_nxt  = '0;
                    cnt_load = 1'b1;
                    if (NCLUST == 1) begin
                        nxt_state = ST_SETTLE;
                        cnt_val   = CNT_W'(SYNC_LAT - 1);
                    end else begin
                        nxt_state = ST_RAMP;
                        cnt_val   = CNT_W'(STAGGER - 1);
                    end
                end
            end
            ST_RAMP: begin
                if (cnt_zero) begin
                    idx_nxt  = idx + IDX_W'(1);
                    cnt_load = 1'b1;
                    if (32'(idx) + 32'd1 == NCLUST - 32'd1) begin
                        nxt_state = ST_SETTLE;
                        cnt_val   = CNT_W'(SYNC_LAT - 1);
                    end else begin
                        cnt_val   = CNT_W'(STAGGER - 1);
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    nxt_state = ST_RUN;
                    cnt_load  = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.wrst_req) begin
                    nxt_state = ST_WRST;
                    cnt_load  = 1'b1;
                    cnt_val   = CNT_W'(RST_HOLD - 1);
                end else if (bus.dbg_req) begin
                    nxt_state = ST_DBG;
                    cnt_load  = 1'b1;
                    cnt_val   = CNT_W'(DBG_WIDTH - 1);
                end
            end
            ST_WRST: begin
                if (cnt_zero) begin
                    nxt_state = ST_SETTLE;
                    cnt_load  = 1'b1;
                    cnt_val   = CNT_W'(SYNC_LAT - 1);
                end
            end
            ST_DBG: begin
                if (bus.wrst_req) begin
                    nxt_state = ST_WRST;
                    cnt_load  = 1'b1;
                    cnt_val   = CNT_W'(RST_HOLD - 1);
                end else if (cnt_zero) begin
                    nxt_state = ST_RUN;
                    cnt_load  = 1'b1;
                end
            end
            default: nxt_state = ST_ASSERT;
        endcase
    end

    // Next registered output values, derived from the current and next state.
    always_comb begin
        cken_nxt = cken_q;
        if (nxt_state == ST_WRST) begin
            cken_nxt = '1;
        end else if ((state == ST_RUN || state == ST_DBG) &&
                     (nxt_state == ST_RUN || nxt_state == ST_DBG)) begin
            cken_nxt = bus.cken_req;
        end else if (state == ST_ASSERT && nxt_state != ST_ASSERT) begin
            cken_nxt = NCLUST'(1);
        end else if (state == ST_RAMP && idx_nxt != idx) begin
            cken_nxt = cken_q | (NCLUST'(1) << idx_nxt);
        end
        grst_nxt = (nxt_state == ST_RUN) || (nxt_state == ST_DBG);
        gdb_nxt  = (nxt_state == ST_RUN);
        busy_nxt = (nxt_state != ST_RUN);
        done_nxt = (state == ST_SETTLE || state == ST_DBG) && (nxt_state == ST_RUN);
    end

    // Output registers.
    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            cken_q <= '0;
            grst_q <= 1'b0;
            gdb_q  <= 1'b0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            cken_q <= cken_nxt;
            grst_q <= grst_nxt;
            gdb_q  <= gdb_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    assign bus.cluster_cken = cken_q;
    assign bus.grst_l       = grst_q;
    assign bus.gdbginit_l   = gdb_q;
    assign bus.seq_busy     = busy_q;
    assign bus.seq_done     = done_q;
endmodule

// File: tb/tb_ctu_cluster_rst_seq.sv
// Scoreboard bench for ctu_cluster_rst_seq with a timeline-based reference model.
module tb_ctu_cluster_rst_seq;
    localparam int NCLUST    = 8;
    localparam int RST_HOLD  = 16;
    localparam int STAGGER   = 4;
    localparam int SYNC_LAT  = 8;
    localparam int DBG_WIDTH = 8;

    logic gclk   = 1'b0;
    logic arst_l = 1'b0;

    ctu_cluster_rst_seq_if #(.NCLUST(NCLUST)) bus ();

    ctu_cluster_rst_seq #(
        .NCLUST    (NCLUST),
        .RST_HOLD  (RST_HOLD),
        .STAGGER   (STAGGER),
        .SYNC_LAT  (SYNC_LAT),
        .DBG_WIDTH (DBG_WIDTH)
    ) dut (
        .gclk   (gclk),
        .arst_l (arst_l),
        .bus    (bus)
    );

    always #5 gclk = ~gclk;

    typedef struct {
        int                cyc;
        logic [NCLUST-1:0] cken;
        logic              grst;
        logic              gdb;
        logic              busy;
        logic              done;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    // Reference model: absolute cycle stamps for pending release / debug end.
    bit m_boot;
    int m_rel_at;
    int m_dbg_end;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", nm, c, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_boot    = 1'b1;
        m_rel_at  = RST_HOLD + 1 + (NCLUST - 1) * STAGGER + SYNC_LAT;
        m_dbg_end = 0;
    endfunction

    // Inputs present during cycle t; predicts the outputs seen in cycle t+1.
    function automatic void model_step(input int t, input logic [NCLUST-1:0] req,
                                       input logic w, input logic d);
        exp_t e;
        int   c;
        c      = t + 1;
        e.cyc  = c;
        e.done = 1'b0;
        if (m_rel_at != 0) begin
            if (m_boot) begin
                for (int k = 0; k < NCLUST; k++)
                    e.cken[k] = (c >= RST_HOLD + 1 + k * STAGGER);
            end else begin
                e.cken = '1;
            end
            if (c == m_rel_at) begin
                e.grst = 1'b1; e.gdb = 1'b1; e.done = 1'b1; e.busy = 1'b0;
                m_rel_at = 0;
                m_boot   = 1'b0;
            end else begin
                e.grst = 1'b0; e.gdb = 1'b0; e.busy = 1'b1;
            end
        end else if (w) begin
            m_rel_at  = c + RST_HOLD + SYNC_LAT;
            m_dbg_end = 0;
            e.cken = '1; e.grst = 1'b0; e.gdb = 1'b0; e.busy = 1'b1;
        end else if (m_dbg_end != 0) begin
            e.cken = req; e.grst = 1'b1;
            if (c == m_dbg_end) begin
                e.gdb = 1'b1; e.done = 1'b1; e.busy = 1'b0;
                m_dbg_end = 0;
            end else begin
                e.gdb = 1'b0; e.busy = 1'b1;
            end
        end else if (d) begin
            m_dbg_end = c + DBG_WIDTH;
            e.cken = req; e.grst = 1'b1; e.gdb = 1'b0; e.busy = 1'b1;
        end else begin
            e.cken = req; e.grst = 1'b1; e.gdb = 1'b1; e.busy = 1'b0;
        end
        q.push_back(e);
    endfunction

    // Monitor: compares DUT outputs against the queued expectation for this cycle.
    always @(negedge gclk) begin
        exp_t e;
        if (mon_en && q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("cluster_cken", e.cyc, 32'(bus.cluster_cken), 32'(e.cken));
            chk("grst_l",       e.cyc, 32'(bus.grst_l),       32'(e.grst));
            chk("gdbginit_l",   e.cyc, 32'(bus.gdbginit_l),   32'(e.gdb));
            chk("seq_busy",     e.cyc, 32'(bus.seq_busy),     32'(e.busy));
            chk("seq_done",     e.cyc, 32'(bus.seq_done),     32'(e.done));
        end
    end

    task automatic tick(input logic [NCLUST-1:0] req, input logic w, input logic d);
        bus.cken_req = req;
        bus.wrst_req = w;
        bus.dbg_req  = d;
        model_step(cyc, req, w, d);
        @(posedge gclk);
        cyc++;
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cken"}, cyc, 32'(bus.cluster_cken), 32'd0);
        chk({tag, "_grst"}, cyc, 32'(bus.grst_l),       32'd0);
        chk({tag, "_gdb"},  cyc, 32'(bus.gdbginit_l),   32'd0);
        chk({tag, "_busy"}, cyc, 32'(bus.seq_busy),     32'd1);
        chk({tag, "_done"}, cyc, 32'(bus.seq_done),     32'd0);
    endtask

    task automatic start_run();
        @(negedge gclk);
        arst_l = 1'b1;
        cyc    = 0;
        q.delete();
        model_reset();
        mon_en = 1'b1;
    endtask

    initial begin
        bus.cken_req = '0;
        bus.wrst_req = 1'b0;
        bus.dbg_req  = 1'b0;
        #12;
        check_reset_vals("por");

        // Power-on with random mask and ignored pulses up to the release edge.
        start_run();
        while (cyc < 60)
            tick(NCLUST'($urandom()), (cyc < 53) && ($urandom_range(0, 3) == 0),
                 (cyc < 53) && ($urandom_range(0, 3) == 0));
        while (cyc < 70) tick(8'hA5, 1'b0, 1'b0);
        tick(8'h3C, 1'b0, 1'b1);
        while (cyc < 100) tick(NCLUST'($urandom()), 1'b0, 1'b0);

        // Same-cycle warm reset and debug request from RUN.
        tick(NCLUST'($urandom()), 1'b1, 1'b1);
        while (cyc < 140) tick(NCLUST'($urandom()), 1'b0, 1'b0);

        // Random traffic.
        repeat (400)
            tick(NCLUST'($urandom()), $urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0);

        // Fresh boot interrupted mid-ramp by the asynchronous reset.
        @(negedge gclk);
        mon_en = 1'b0;
        arst_l = 1'b0;
        start_run();
        while (cyc < 30) tick(NCLUST'($urandom()), 1'b0, 1'b0);
        @(negedge gclk);
        #1;
        mon_en = 1'b0;
        q.delete();
        arst_l = 1'b0;
        #1;
        check_reset_vals("midramp");
        #20;

        // Restarted timeline: debug at 70 aborted by warm reset at 73.
        start_run();
        while (cyc < 70) tick(NCLUST'($urandom()), 1'b0, 1'b0);
        tick(NCLUST'($urandom()), 1'b0, 1'b1);
        while (cyc < 73) tick(NCLUST'($urandom()), 1'b0, 1'b0);
        tick(NCLUST'($urandom()), 1'b1, 1'b0);
        while (cyc < 110) tick(NCLUST'($urandom()), 1'b0, 1'b0);

        @(negedge gclk);
        #1;
        chk("queue_drain", cyc, 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ctu_cluster_rst_seq.md
# ctu_cluster_rst_seq

Central clock/reset sequencer that generates the per-cluster `cluster_cken`, the global `grst_l` and the global `gdbginit_l` consumed by every cluster clock header. After power-on it holds reset, then enables cluster clocks one at a time at staggered intervals to limit di/dt. It then releases reset and debug-init once the headers' synchronizers have settled. During run it services warm-reset and debug-init requests, and applies the software clock-enable mask.

## Interface
Parameters:
- `NCLUST`, 8: number of clusters driven; must be ≥1.
- `RST_HOLD`, 16: cycles reset is held before the clock ramp or warm-reset settle; must be ≥1.
- `STAGGER`, 4: cycles between successive cluster enables during the ramp; must be ≥1.
- `SYNC_LAT`, 8: cycles from the last clock-enable change to reset release; covers header sync latency; must be ≥1.
- `DBG_WIDTH`, 8: cycles `gdbginit_l` is held low for a debug init; must be ≥1.

Ports:
- `gclk` in 1: global clock; the only clock.
- `arst_l` in 1: asynchronous active-low reset.
- `cken_req` in NCLUST: software clock-enable mask; applied only in RUN.
- `wrst_req` in 1: warm-reset request, single-cycle pulse.
- `dbg_req` in 1: debug-init request, single-cycle pulse.
- `cluster_cken` out NCLUST: per-cluster clock enable to the headers.
- `grst_l` out 1: global reset to the headers, active-low.
- `gdbginit_l` out 1: global debug init to the headers, active-low.
- `seq_busy` out 1: high whenever the state is not RUN.
- `seq_done` out 1: one-cycle pulse when a sequence completes.

## Operation
- All outputs are registered. Reset values: `cluster_cken`=0, `grst_l`=0, `gdbginit_l`=0, `seq_busy`=1, `seq_done`=0. The state is ASSERT with the counter at 0.
- **ASSERT:** All outputs hold their reset values for RST_HOLD cycles, then the block enters RAMP.
- **RAMP:**
  - `cluster_cken[0]` sets on the first RAMP cycle.
  - `cluster_cken[k]` sets k·STAGGER cycles later.
  - Every cluster is enabled; the mask is ignored in RAMP.
  - After bit NCLUST-1 sets, the block enters SETTLE.
- **SETTLE:** After SYNC_LAT cycles, `grst_l` and `gdbginit_l` rise together. `seq_done` pulses in that same cycle and the block enters RUN.
- **RUN:**
  - `cluster_cken` <= `cken_req` with one-cycle latency.
  - `seq_busy`=0.
- **WRST** (entered from RUN or DBG on `wrst_req`):
  - `grst_l`=0, `gdbginit_l`=0 and `cluster_cken` forced all-ones on the next cycle.
  - Held for RST_HOLD cycles, then the block enters SETTLE. SETTLE proceeds exactly as after power-on.
- **DBG** (entered from RUN on `dbg_req`):
  - `gdbginit_l`=0 for DBG_WIDTH cycles; `grst_l` stays 1; `cluster_cken` keeps tracking `cken_req`.
  - Then `gdbginit_l`=1 and `seq_done` pulses in the same cycle, and the block returns to RUN.
- **Request priority and filtering:**
  - If `wrst_req` and `dbg_req` arrive in the same cycle, `wrst_req` wins.
  - `wrst_req` in DBG aborts the debug init and enters WRST.
  - `wrst_req` in ASSERT, RAMP, SETTLE or WRST is ignored.
  - `dbg_req` outside RUN is ignored; it is not queued.
- `arst_l` assertion at any point returns all outputs to reset values asynchronously. A sequence interrupted mid-flight restarts from ASSERT.
- Counter: a single down-counter of width $clog2(max(RST_HOLD, STAGGER, SYNC_LAT, DBG_WIDTH)+1). It is loaded on each state entry and on each RAMP step. The cluster index uses $clog2(NCLUST) bits with a minimum of 1 bit. Neither wraps.

## Timing
- Cycle 1 is the first `gclk` rising edge with `arst_l` high.
- ASSERT covers cycles 1..RST_HOLD.
- `cluster_cken[k]` rises at cycle RST_HOLD+1+k·STAGGER.
- `grst_l`, `gdbginit_l` and `seq_done` rise SYNC_LAT cycles after the last cken rise. With defaults: last cken at cycle 45, reset release at cycle 53.
- Warm reset:
  - `wrst_req` sampled at edge t: `grst_l` falls at t+1.
  - `grst_l` rises at t+1+RST_HOLD+SYNC_LAT.
- Debug init: `dbg_req` sampled at t gives `gdbginit_l` low for cycles t+1..t+DBG_WIDTH, and it rises at t+DBG_WIDTH+1.
- A mask change sampled at t appears on `cluster_cken` at t+1.

## Structure
- Package `ctu_rst_seq_pkg` holds:
  - the state enum (ASSERT, RAMP, SETTLE, RUN, WRST, DBG);
  - a `seq_cnt_w` function computing counter width from the parameters.
- Sub-module `ctu_seq_cnt` is a loadable down-counter with ports `load`, `load_val` and `zero`. It is instantiated once; the FSM lives in the top.

## Test plan
- Power-on with default parameters:
  - `cluster_cken` bits rise at cycles 17, 21, …, 45;
  - `grst_l`, `gdbginit_l` and `seq_done` rise at cycle 53;
  - `seq_busy` falls at cycle 53.
- RUN with `cken_req`=8'hA5 at cycle 60 → `cluster_cken`=8'hA5 at cycle 61; `grst_l` stays 1.
- `dbg_req` at cycle 70 → `gdbginit_l` low cycles 71–78, high at 79 with `seq_done`; `grst_l` constantly 1.
- `dbg_req` at cycle 70 and `wrst_req` at cycle 73:
  - `grst_l` low at 74;
  - `cluster_cken`=8'hFF at 74;
  - release at 74+16+8=98.
- Same-cycle `wrst_req`+`dbg_req` → WRST path only. `dbg_req` during RAMP → no effect; the power-on timeline is unchanged.
- `arst_l` asserted at cycle 30 (mid-RAMP) → all outputs return to reset values immediately. After release, the full timeline restarts from cycle 1.
